// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the coherence bus controller: bus words, RAM status and bus FSM states.
package coherence_bus_ctrl_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IFETCH  = 3'd1,
      DWRITE  = 3'd2,
      SNOOP   = 3'd3,
      SNPRESP = 3'd4,
      FWD     = 3'd5,
      RAMRD   = 3'd6,
      INVAL   = 3'd7
   } bus_state_t;

   // Block address of a two-word line (word-in-block bit cleared).
   localparam word_t BLK_MASK = 32'hFFFF_FFFB;
   // Address presented to the peer on an invalidation.
   localparam word_t INV_MASK = 32'hFFFF_FFF8;

   // Bit 2 selects the second word of a line; it marks the last word of a transfer.
   function automatic logic last_word(input word_t addr);
      return addr[2];
   endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter2.sv
// Two-request round-robin arbiter; the pointer remembers the last winner and
// is loaded from outside so several instances can share one pointer value.
module coherence_bus_ctrl_rr_arbiter2 (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [1:0] req,
   input  logic       upd_en,
   input  logic       upd_idx,
   output logic       valid,
   output logic       gnt
);

   logic last_reg;

   // Pointer register: after reset core 1 counts as last winner so core 0 goes first.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         last_reg <= 1'b1;
      else if (upd_en)
         last_reg <= upd_idx;
   end

   // Winner selection: on contention the core that did not win last time goes.
   always_comb begin
      valid = |req;
      if (req == 2'b11)
         gnt = ~last_reg;
      else
         gnt = req[1];
   end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping bus controller between two cores' icache/dcache pairs and one RAM port.
// Serves data requests before instruction fetches, snoops on fills, forwards
// Modified lines cache-to-cache while writing them back, and issues invalidations.
module coherence_bus_ctrl
   import coherence_bus_ctrl_pkg::*;
#(
   parameter int NCPU = 2
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic [NCPU-1:0] iREN,
   input  word_t           iaddr [NCPU],
   output logic [NCPU-1:0] iwait,
   output word_t           iload [NCPU],
   input  logic [NCPU-1:0] dREN,
   input  logic [NCPU-1:0] dWEN,
   input  word_t           daddr [NCPU],
   input  word_t           dstore [NCPU],
   output logic [NCPU-1:0] dwait,
   output word_t           dload [NCPU],
   input  logic [NCPU-1:0] cctrans,
   input  logic [NCPU-1:0] ccwrite,
   output logic [NCPU-1:0] ccwait,
   output logic [NCPU-1:0] ccinv,
   output word_t           ccsnoopaddr [NCPU],
   output logic            ramREN,
   output logic            ramWEN,
   output word_t           ramaddr,
   output word_t           ramstore,
   input  word_t           ramload,
   input  ramstate_t       ramstate
);

   bus_state_t      state_reg, state_next;
   logic            g_reg, g_next;
   logic            p;
   logic            grant_fire;
   logic            ack;
   logic [NCPU-1:0] dreq;
   logic            d_valid, d_gnt, i_valid, i_gnt;

   // Per-role results of the FSM, fanned out to the granted core and its peer below.
   logic            g_dack, p_dack, g_iack;
   word_t           g_dload, g_iload;
   logic            p_ccwait, p_ccinv;
   word_t           p_snoop;

   assign p   = ~g_reg;
   assign ack = (ramstate == ACCESS);

   // Both arbiters load the same winner on every grant, so they share one pointer value.
   coherence_bus_ctrl_rr_arbiter2 u_darb (
      .CLK     (CLK),
      .nRST    (nRST),
      .req     (dreq),
      .upd_en  (grant_fire),
      .upd_idx (g_next),
      .valid   (d_valid),
      .gnt     (d_gnt)
   );

   coherence_bus_ctrl_rr_arbiter2 u_iarb (
      .CLK     (CLK),
      .nRST    (nRST),
      .req     (iREN),
      .upd_en  (grant_fire),
      .upd_idx (g_next),
      .valid   (i_valid),
      .gnt     (i_gnt)
   );

   // State and grant registers; reset aborts any transaction at once.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg <= IDLE;
         g_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         g_reg     <= g_next;
      end
   end

   // Next-state decode and role-level outputs; a dropped request returns to IDLE silently.
   always_comb begin
      state_next = state_reg;
      g_next     = g_reg;
      grant_fire = 1'b0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      g_dack     = 1'b0;
      p_dack     = 1'b0;
      g_iack     = 1'b0;
      g_dload    = '0;
      g_iload    = '0;
      p_ccwait   = 1'b0;
      p_ccinv    = 1'b0;
      p_snoop    = '0;
      case (state_reg)
         IDLE: begin
            if (d_valid) begin
               grant_fire = 1'b1;
               g_next     = d_gnt;
               if (dWEN[d_gnt])
                  state_next = DWRITE;
               else if (dREN[d_gnt] && cctrans[d_gnt])
                  state_next = SNOOP;
               else if (cctrans[d_gnt])
                  state_next = INVAL;
               else
                  state_next = RAMRD;
            end else if (i_valid) begin
               grant_fire = 1'b1;
               g_next     = i_gnt;
               state_next = IFETCH;
            end
         end
         IFETCH: begin
            if (!iREN[g_reg]) begin
               state_next = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr[g_reg];
               g_iload = ramload;
               g_iack  = ack;
               if (ack)
                  state_next = IDLE;
            end
         end
         DWRITE: begin
            if (!dWEN[g_reg]) begin
               state_next = IDLE;
            end else begin
               ramWEN   = 1'b1;
               ramaddr  = daddr[g_reg];
               ramstore = dstore[g_reg];
               g_dack   = ack;
               if (ack && last_word(daddr[g_reg]))
                  state_next = IDLE;
            end
         end
         SNOOP, SNPRESP: begin
            if (!dREN[g_reg]) begin
               state_next = IDLE;
            end else begin
               p_ccwait = 1'b1;
               p_snoop  = daddr[g_reg] & BLK_MASK;
               if (state_reg == SNOOP)
                  state_next = SNPRESP;
               else if (cctrans[p])
                  state_next = FWD;
               else
                  state_next = RAMRD;
            end
         end
         FWD: begin
            if (!dREN[g_reg]) begin
               state_next = IDLE;
            end else begin
               p_ccwait = 1'b1;
               p_snoop  = daddr[g_reg] & BLK_MASK;
               ramWEN   = 1'b1;
               ramaddr  = daddr[p];
               ramstore = dstore[p];
               g_dload  = dstore[p];
               g_dack   = ack;
               p_dack   = ack;
               if (ack && last_word(daddr[p])) begin
                  p_ccinv    = ccwrite[g_reg];
                  state_next = IDLE;
               end
            end
         end
         RAMRD: begin
            if (!dREN[g_reg]) begin
               state_next = IDLE;
            end else begin
               // A requester still holding cctrans came through SNOOP and keeps the peer blocked.
               p_ccwait = cctrans[g_reg];
               if (cctrans[g_reg])
                  p_snoop = daddr[g_reg] & BLK_MASK;
               ramREN  = 1'b1;
               ramaddr = daddr[g_reg];
               g_dload = ramload;
               g_dack  = ack;
               if (ack && last_word(daddr[g_reg])) begin
                  p_ccinv    = ccwrite[g_reg] & cctrans[g_reg];
                  state_next = IDLE;
               end
            end
         end
         INVAL: begin
            state_next = IDLE;
            if (cctrans[g_reg]) begin
               p_ccwait = 1'b1;
               p_ccinv  = 1'b1;
               p_snoop  = daddr[g_reg] & INV_MASK;
               g_dack   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Fan role-level results out to each core according to whether it is granted or the peer.
   genvar gi;
   generate
      for (gi = 0; gi < NCPU; gi++) begin : g_core
         localparam logic ME = 1'(gi);
         assign dreq[gi]        = dREN[gi] | dWEN[gi] | cctrans[gi];
         assign dwait[gi]       = ~(((g_reg == ME) && g_dack) || ((p == ME) && p_dack));
         assign dload[gi]       = (g_reg == ME) ? g_dload : '0;
         assign iwait[gi]       = ~((g_reg == ME) && g_iack);
         assign iload[gi]       = (g_reg == ME) ? g_iload : '0;
         assign ccwait[gi]      = (p == ME) && p_ccwait;
         assign ccinv[gi]       = (p == ME) && p_ccinv;
         assign ccsnoopaddr[gi] = (p == ME) ? p_snoop : '0;
      end
   endgenerate

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: inputs change 1 ns after the rising edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_coherence_bus_ctrl;
   import coherence_bus_ctrl_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic [1:0] iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
   word_t      iaddr [2];
   word_t      iload [2];
   word_t      daddr [2];
   word_t      dstore [2];
   word_t      dload [2];
   word_t      ccsnoopaddr [2];
   logic       ramREN, ramWEN;
   word_t      ramaddr, ramstore, ramload;
   ramstate_t  ramstate;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   coherence_bus_ctrl #(.NCPU(2)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .iREN        (iREN),
      .iaddr       (iaddr),
      .iwait       (iwait),
      .iload       (iload),
      .dREN        (dREN),
      .dWEN        (dWEN),
      .daddr       (daddr),
      .dstore      (dstore),
      .dwait       (dwait),
      .dload       (dload),
      .cctrans     (cctrans),
      .ccwrite     (ccwrite),
      .ccwait      (ccwait),
      .ccinv       (ccinv),
      .ccsnoopaddr (ccsnoopaddr),
      .ramREN      (ramREN),
      .ramWEN      (ramWEN),
      .ramaddr     (ramaddr),
      .ramstore    (ramstore),
      .ramload     (ramload),
      .ramstate    (ramstate)
   );

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic clr_inputs();
      iREN     = 2'b00;
      dREN     = 2'b00;
      dWEN     = 2'b00;
      cctrans  = 2'b00;
      ccwrite  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         iaddr[i]  = '0;
         daddr[i]  = '0;
         dstore[i] = '0;
      end
      ramload  = '0;
      ramstate = FREE;
   endtask

   initial begin
      nRST = 1'b0;
      clr_inputs();
      #2;
      // Reset values
      chk("rst dwait",   32'(dwait),   32'h3);
      chk("rst iwait",   32'(iwait),   32'h3);
      chk("rst ccwait",  32'(ccwait),  32'h0);
      chk("rst ccinv",   32'(ccinv),   32'h0);
      chk("rst ramREN",  32'(ramREN),  32'h0);
      chk("rst ramWEN",  32'(ramWEN),  32'h0);
      chk("rst ramaddr", ramaddr,      32'h0);
      chk("rst snoop1",  ccsnoopaddr[1], 32'h0);
      chk("rst dload0",  dload[0],     32'h0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // T1: core0 fill, no peer copy, RAM latency 2
      dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h100;
      mid(); chk("t1 idle ramREN", 32'(ramREN), 32'h0); chk("t1 idle ccwait", 32'(ccwait), 32'h0); adv();
      mid(); chk("t1 snoop ccwait", 32'(ccwait), 32'h2); chk("t1 snoop addr", ccsnoopaddr[1], 32'h100);
             chk("t1 snoop dwait", 32'(dwait), 32'h3); adv();
      mid(); chk("t1 snpresp ccwait", 32'(ccwait), 32'h2); chk("t1 snpresp ramREN", 32'(ramREN), 32'h0); adv();
      ramstate = BUSY;
      mid(); chk("t1 w0 ramREN", 32'(ramREN), 32'h1); chk("t1 w0 ramaddr", ramaddr, 32'h100);
             chk("t1 w0 busy dwait", 32'(dwait), 32'h3); chk("t1 w0 busy ccwait", 32'(ccwait), 32'h2); adv();
      ramstate = ACCESS; ramload = 32'h1111_0000;
      mid(); chk("t1 w0 dwait", 32'(dwait), 32'h2); chk("t1 w0 dload", dload[0], 32'h1111_0000);
             chk("t1 w0 ccinv", 32'(ccinv), 32'h0); chk("t1 w0 ccwait", 32'(ccwait), 32'h2); adv();
      daddr[0] = 32'h104; ramstate = BUSY;
      mid(); chk("t1 w1 busy ccwait", 32'(ccwait), 32'h2); chk("t1 w1 busy dwait", 32'(dwait), 32'h3);
             chk("t1 w1 ramaddr", ramaddr, 32'h104); adv();
      ramstate = ACCESS; ramload = 32'h2222_0000;
      mid(); chk("t1 w1 dwait", 32'(dwait), 32'h2); chk("t1 w1 dload", dload[0], 32'h2222_0000);
             chk("t1 w1 ccinv", 32'(ccinv), 32'h0); chk("t1 w1 ccwait", 32'(ccwait), 32'h2); adv();
      clr_inputs();
      mid(); chk("t1 end ccwait", 32'(ccwait), 32'h0); chk("t1 end ramREN", 32'(ramREN), 32'h0);
             chk("t1 end dwait", 32'(dwait), 32'h3); adv();

      // T2: core0 write-intent fill, core1 holds the line Modified and forwards it
      dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h100;
      adv();
      mid(); chk("t2 snoop ccwait", 32'(ccwait), 32'h2); adv();
      cctrans[1] = 1'b1; dWEN[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'h0000_AAAA;
      mid(); chk("t2 snpresp ccwait", 32'(ccwait), 32'h2); chk("t2 snpresp ramWEN", 32'(ramWEN), 32'h0); adv();
      ramstate = BUSY;
      mid(); chk("t2 fwd ramWEN", 32'(ramWEN), 32'h1); chk("t2 fwd ramaddr", ramaddr, 32'h100);
             chk("t2 fwd ramstore", ramstore, 32'h0000_AAAA); chk("t2 fwd dload0", dload[0], 32'h0000_AAAA);
             chk("t2 fwd busy dwait", 32'(dwait), 32'h3); adv();
      ramstate = ACCESS;
      mid(); chk("t2 w0 dwait", 32'(dwait), 32'h0); chk("t2 w0 ccinv", 32'(ccinv), 32'h0); adv();
      daddr[1] = 32'h104; dstore[1] = 32'h0000_BBBB; daddr[0] = 32'h104;
      mid(); chk("t2 w1 dload0", dload[0], 32'h0000_BBBB); chk("t2 w1 ramaddr", ramaddr, 32'h104);
             chk("t2 w1 dwait", 32'(dwait), 32'h0); chk("t2 w1 ccinv", 32'(ccinv), 32'h2);
             chk("t2 w1 ccwait", 32'(ccwait), 32'h2); adv();
      clr_inputs();
      mid(); chk("t2 end ccwait", 32'(ccwait), 32'h0); chk("t2 end ramWEN", 32'(ramWEN), 32'h0); adv();

      // T3: core1 invalidation of 0x208
      cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h208;
      adv();
      mid(); chk("t3 inv ccwait", 32'(ccwait), 32'h1); chk("t3 inv ccinv", 32'(ccinv), 32'h1);
             chk("t3 inv addr", ccsnoopaddr[0], 32'h208); chk("t3 inv dwait", 32'(dwait), 32'h1); adv();
      clr_inputs();
      mid(); chk("t3 after ccwait", 32'(ccwait), 32'h0); chk("t3 after ccinv", 32'(ccinv), 32'h0); adv();

      // T4: both cores write back; round-robin alternation on repeated contention
      dWEN = 2'b11; daddr[0] = 32'h300; dstore[0] = 32'hA0; daddr[1] = 32'h400; dstore[1] = 32'h1B0;
      mid(); chk("t4 idle ramWEN", 32'(ramWEN), 32'h0); adv();
      ramstate = ACCESS;
      mid(); chk("t4 c0w0 ramWEN", 32'(ramWEN), 32'h1); chk("t4 c0w0 ramaddr", ramaddr, 32'h300);
             chk("t4 c0w0 ramstore", ramstore, 32'hA0); chk("t4 c0w0 dwait", 32'(dwait), 32'h2); adv();
      daddr[0] = 32'h304; dstore[0] = 32'hA4;
      mid(); chk("t4 c0w1 ramaddr", ramaddr, 32'h304); chk("t4 c0w1 ramstore", ramstore, 32'hA4);
             chk("t4 c0w1 dwait", 32'(dwait), 32'h2); adv();
      dWEN[0] = 1'b0; ramstate = FREE;
      mid(); chk("t4 gap ramWEN", 32'(ramWEN), 32'h0); chk("t4 gap dwait", 32'(dwait), 32'h3); adv();
      ramstate = ACCESS;
      mid(); chk("t4 c1w0 ramaddr", ramaddr, 32'h400); chk("t4 c1w0 ramstore", ramstore, 32'h1B0);
             chk("t4 c1w0 dwait", 32'(dwait), 32'h1); adv();
      daddr[1] = 32'h404; dstore[1] = 32'h1B4;
      mid(); chk("t4 c1w1 ramaddr", ramaddr, 32'h404); chk("t4 c1w1 dwait", 32'(dwait), 32'h1); adv();
      dWEN[0] = 1'b1; daddr[0] = 32'h504; dstore[0] = 32'hC0; daddr[1] = 32'h604; dstore[1] = 32'hD0;
      ramstate = FREE;
      mid(); chk("t4 rr2 idle ramWEN", 32'(ramWEN), 32'h0); adv();
      ramstate = ACCESS;
      mid(); chk("t4 rr2 winner", ramaddr, 32'h504); chk("t4 rr2 dwait", 32'(dwait), 32'h2); adv();
      ramstate = FREE;
      mid(); chk("t4 rr3 idle ramWEN", 32'(ramWEN), 32'h0); adv();
      ramstate = ACCESS;
      mid(); chk("t4 rr3 winner", ramaddr, 32'h604); chk("t4 rr3 dwait", 32'(dwait), 32'h1); adv();
      clr_inputs();
      mid(); chk("t4 end ramWEN", 32'(ramWEN), 32'h0); adv();

      // T5: data request beats an instruction fetch; ERROR stalls like BUSY
      iREN[0] = 1'b1; iaddr[0] = 32'h40; dREN[1] = 1'b1; daddr[1] = 32'h804;
      mid(); chk("t5 idle iwait", 32'(iwait), 32'h3); chk("t5 idle ramREN", 32'(ramREN), 32'h0); adv();
      ramstate = ACCESS; ramload = 32'h5555;
      mid(); chk("t5 rd ramREN", 32'(ramREN), 32'h1); chk("t5 rd ramaddr", ramaddr, 32'h804);
             chk("t5 rd dload1", dload[1], 32'h5555); chk("t5 rd dwait", 32'(dwait), 32'h1);
             chk("t5 rd iwait", 32'(iwait), 32'h3); chk("t5 rd ccwait", 32'(ccwait), 32'h0); adv();
      dREN[1] = 1'b0; ramstate = FREE;
      mid(); chk("t5 gap iwait", 32'(iwait), 32'h3); chk("t5 gap ramREN", 32'(ramREN), 32'h0); adv();
      ramstate = ERROR;
      mid(); chk("t5 if ramREN", 32'(ramREN), 32'h1); chk("t5 if ramaddr", ramaddr, 32'h40);
             chk("t5 if error iwait", 32'(iwait), 32'h3); adv();
      ramstate = ACCESS; ramload = 32'h1234;
      mid(); chk("t5 if iwait", 32'(iwait), 32'h2); chk("t5 if iload0", iload[0], 32'h1234); adv();
      clr_inputs();
      mid(); chk("t5 end iwait", 32'(iwait), 32'h3); chk("t5 end ramREN", 32'(ramREN), 32'h0); adv();

      // T6: reset asserted during the first forward word
      dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h100;
      adv();
      mid(); chk("t6 snoop ccwait", 32'(ccwait), 32'h2); adv();
      cctrans[1] = 1'b1; dWEN[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'h0000_CCCC;
      adv();
      ramstate = BUSY;
      #1;
      chk("t6 fwd ramWEN", 32'(ramWEN), 32'h1); chk("t6 fwd ccwait", 32'(ccwait), 32'h2);
      nRST = 1'b0;
      #1;
      chk("t6 rst ccwait", 32'(ccwait), 32'h0); chk("t6 rst ramWEN", 32'(ramWEN), 32'h0);
      chk("t6 rst dwait", 32'(dwait), 32'h3); chk("t6 rst ramaddr", ramaddr, 32'h0);
      clr_inputs();
      adv();
      nRST = 1'b1;
      dWEN = 2'b11; daddr[0] = 32'h904; dstore[0] = 32'h9; daddr[1] = 32'hA04; dstore[1] = 32'hA;
      mid(); chk("t6 idle ramWEN", 32'(ramWEN), 32'h0); chk("t6 idle ccwait", 32'(ccwait), 32'h0); adv();
      ramstate = ACCESS;
      mid(); chk("t6 prio ramaddr", ramaddr, 32'h904); chk("t6 prio dwait", 32'(dwait), 32'h2); adv();
      clr_inputs();
      adv();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
